// File: rtl/ch2_piso_ser.sv
// ch2_piso_ser: parametrised parallel-in/serial-out shift register.
// A word is loaded through a valid/ready handshake and shifted out one bit
// per SHIFT_EN-qualified clock, with Q_VALID/Q_LAST framing. A new word can
// be accepted on the final-bit edge, so consecutive frames have no gap.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit
// (XOR of the captured word) after the data bits, making frames WIDTH+1 long.
module ch2_piso_ser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD_VALID,
    output logic             LD_READY,
    input  logic [WIDTH-1:0] D,
    input  logic             SHIFT_EN,
    output logic             Q,
    output logic             Q_VALID,
    output logic             Q_LAST,
    output logic             BUSY
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             head_bit;
    logic             serial_bit;
    logic [WIDTH-1:0] sr_shifted;
    logic             busy;
    logic             at_last;
    logic             accept;

`ifdef PISO_PARITY_EN
    logic parity_q, parity_d;
`endif

    // Head bit and one-step shift depend only on the shift direction.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign head_bit   = sr_q[WIDTH-1];
            assign sr_shifted = {sr_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign head_bit   = sr_q[0];
            assign sr_shifted = {1'b0, sr_q[WIDTH-1:1]};
        end
    endgenerate

    // Once all data bits have gone, the stored parity bit takes the line.
`ifdef PISO_PARITY_EN
    assign serial_bit = (cnt_q == CW'(WIDTH)) ? parity_q : head_bit;
`else
    assign serial_bit = head_bit;
`endif

    // Framing outputs; ready in SHIFT only on an advancing final-bit cycle.
    assign busy     = (state_q == SHIFT);
    assign at_last  = busy && (cnt_q == LAST_CNT);
    assign Q        = busy & serial_bit;
    assign Q_VALID  = busy;
    assign Q_LAST   = at_last;
    assign BUSY     = busy;
    assign LD_READY = !busy || (at_last && SHIFT_EN);
    assign accept   = LD_VALID && LD_READY;

    // Next-state logic: load, shift, or finish the frame; hold by default.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    sr_d    = D;
                    cnt_d   = '0;
`ifdef PISO_PARITY_EN
                    parity_d = ^D;
`endif
                end
            end
            SHIFT: begin
                if (SHIFT_EN) begin
                    if (at_last) begin
                        if (accept) begin
                            // Back-to-back: next frame starts on the very next cycle.
                            sr_d  = D;
                            cnt_d = '0;
`ifdef PISO_PARITY_EN
                            parity_d = ^D;
`endif
                        end else begin
                            state_d = IDLE;
                            sr_d    = '0;
                            cnt_d   = '0;
`ifdef PISO_PARITY_EN
                            parity_d = 1'b0;
`endif
                        end
                    end else begin
                        sr_d  = sr_shifted;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shift register and counter; reset discards any word in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_ch2_piso_ser.sv
// tb_ch2_piso_ser: drives an MSB-first and an LSB-first instance with the
// same stimulus and checks both against a queue of expected frame bits.
// Honours PISO_PARITY_EN so the expected frames match the build.
module tb_ch2_piso_ser;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ld_valid = 1'b0;
    logic [W-1:0] d = '0;
    logic         shift_en = 1'b0;

    logic m_rdy, m_q, m_qv, m_ql, m_busy;
    logic l_rdy, l_q, l_qv, l_ql, l_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry: {expected bit, expected last flag}
    logic [1:0] q_msb[$];
    logic [1:0] q_lsb[$];

    wire [4:0] obs_m = {m_q, m_qv, m_ql, m_busy, m_rdy};
    wire [4:0] obs_l = {l_q, l_qv, l_ql, l_busy, l_rdy};

    always #5 clk = ~clk;

    ch2_piso_ser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .CLK(clk), .RST(rst), .LD_VALID(ld_valid), .LD_READY(m_rdy), .D(d),
        .SHIFT_EN(shift_en), .Q(m_q), .Q_VALID(m_qv), .Q_LAST(m_ql), .BUSY(m_busy)
    );

    ch2_piso_ser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .CLK(clk), .RST(rst), .LD_VALID(ld_valid), .LD_READY(l_rdy), .D(d),
        .SHIFT_EN(shift_en), .Q(l_q), .Q_VALID(l_qv), .Q_LAST(l_ql), .BUSY(l_busy)
    );

    // Reference model of one frame position.
    function automatic logic [1:0] exp_entry(input logic [W-1:0] w, input int idx, input bit msb);
        logic b;
        if (idx < W) b = msb ? w[W-1-idx] : w[idx];
        else         b = ^w;
        return {b, (idx == FL - 1)};
    endfunction

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < FL; i++) begin
            q_msb.push_back(exp_entry(w, i, 1'b1));
            q_lsb.push_back(exp_entry(w, i, 1'b0));
        end
    endtask

    task automatic test_reset();
        logic [4:0] e;
        ld_valid = 1'b0; shift_en = 1'b0; d = '0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        e = 5'b00001;
        n_checks++;
        if (obs_m !== e) begin n_fail++; $display("FAIL reset_msb got=%b exp=%b", obs_m, e); end
        n_checks++;
        if (obs_l !== e) begin n_fail++; $display("FAIL reset_lsb got=%b exp=%b", obs_l, e); end
        rst = 1'b0;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_frame(input logic [W-1:0] w, input string name);
        logic [1:0] em, el;
        logic [4:0] xm, xl;
        @(negedge clk);
        ld_valid = 1'b1; d = w; shift_en = 1'b1;
        push_word(w);
        for (int t = 1; t <= FL; t++) begin
            @(negedge clk);
            em = q_msb.pop_front(); el = q_lsb.pop_front();
            xm = {em[1], 1'b1, em[0], 1'b1, em[0] & shift_en};
            xl = {el[1], 1'b1, el[0], 1'b1, el[0] & shift_en};
            n_checks++;
            if (obs_m !== xm) begin n_fail++; $display("FAIL %s_msb w=%b t=%0d got=%b exp=%b", name, w, t, obs_m, xm); end
            n_checks++;
            if (obs_l !== xl) begin n_fail++; $display("FAIL %s_lsb w=%b t=%0d got=%b exp=%b", name, w, t, obs_l, xl); end
            ld_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (obs_m !== 5'b00001) begin n_fail++; $display("FAIL %s_idle_msb got=%b exp=00001", name, obs_m); end
        n_checks++;
        if (obs_l !== 5'b00001) begin n_fail++; $display("FAIL %s_idle_lsb got=%b exp=00001", name, obs_l); end
        $display("%s: word %b shifted out", name, w);
    endtask

    task automatic test_back_to_back(input logic [W-1:0] w1, input logic [W-1:0] w2);
        logic [1:0] em, el;
        logic [4:0] xm, xl;
        @(negedge clk);
        ld_valid = 1'b1; d = w1; shift_en = 1'b1;
        push_word(w1);
        for (int t = 1; t <= 2 * FL; t++) begin
            @(negedge clk);
            em = q_msb.pop_front(); el = q_lsb.pop_front();
            xm = {em[1], 1'b1, em[0], 1'b1, em[0] & shift_en};
            xl = {el[1], 1'b1, el[0], 1'b1, el[0] & shift_en};
            n_checks++;
            if (obs_m !== xm) begin n_fail++; $display("FAIL b2b_msb t=%0d got=%b exp=%b", t, obs_m, xm); end
            n_checks++;
            if (obs_l !== xl) begin n_fail++; $display("FAIL b2b_lsb t=%0d got=%b exp=%b", t, obs_l, xl); end
            if (t == 1) begin d = w2; push_word(w2); end
            if (t == FL + 1) ld_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (obs_m !== 5'b00001) begin n_fail++; $display("FAIL b2b_idle_msb got=%b exp=00001", obs_m); end
        n_checks++;
        if (obs_l !== 5'b00001) begin n_fail++; $display("FAIL b2b_idle_lsb got=%b exp=00001", obs_l); end
        $display("back_to_back: words %b,%b shifted out", w1, w2);
    endtask

    task automatic test_stall(input logic [W-1:0] w);
        logic [1:0] em, el;
        logic [4:0] xm, xl;
        bit adv;
        int tl;
        tl = FL + 3;
        em = '0; el = '0;
        @(negedge clk);
        ld_valid = 1'b1; d = w; shift_en = 1'b1;
        push_word(w);
        adv = 1'b1;
        for (int t = 1; t <= tl + 2; t++) begin
            @(negedge clk);
            if (adv) begin em = q_msb.pop_front(); el = q_lsb.pop_front(); end
            xm = {em[1], 1'b1, em[0], 1'b1, em[0] & shift_en};
            xl = {el[1], 1'b1, el[0], 1'b1, el[0] & shift_en};
            n_checks++;
            if (obs_m !== xm) begin n_fail++; $display("FAIL stall_msb t=%0d got=%b exp=%b", t, obs_m, xm); end
            n_checks++;
            if (obs_l !== xl) begin n_fail++; $display("FAIL stall_lsb t=%0d got=%b exp=%b", t, obs_l, xl); end
            if (t == 1) ld_valid = 1'b0;
            if (t == 2) shift_en = 1'b0;
            if (t == 5) shift_en = 1'b1;
            if (t == tl) begin shift_en = 1'b0; ld_valid = 1'b1; d = 4'b1111; end
            if (t == tl + 2) begin shift_en = 1'b1; ld_valid = 1'b0; end
            adv = shift_en;
        end
        @(negedge clk);
        n_checks++;
        if (obs_m !== 5'b00001) begin n_fail++; $display("FAIL stall_idle_msb got=%b exp=00001", obs_m); end
        n_checks++;
        if (obs_l !== 5'b00001) begin n_fail++; $display("FAIL stall_idle_lsb got=%b exp=00001", obs_l); end
        $display("stall: word %b shifted out with holds", w);
    endtask

    task automatic test_reset_midframe(input logic [W-1:0] w);
        logic [1:0] em, el;
        logic [4:0] xm, xl;
        @(negedge clk);
        ld_valid = 1'b1; d = w; shift_en = 1'b1;
        push_word(w);
        for (int t = 1; t <= 2; t++) begin
            @(negedge clk);
            em = q_msb.pop_front(); el = q_lsb.pop_front();
            xm = {em[1], 1'b1, em[0], 1'b1, em[0] & shift_en};
            xl = {el[1], 1'b1, el[0], 1'b1, el[0] & shift_en};
            n_checks++;
            if (obs_m !== xm) begin n_fail++; $display("FAIL rstmid_msb t=%0d got=%b exp=%b", t, obs_m, xm); end
            n_checks++;
            if (obs_l !== xl) begin n_fail++; $display("FAIL rstmid_lsb t=%0d got=%b exp=%b", t, obs_l, xl); end
            ld_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs_m !== 5'b00001) begin n_fail++; $display("FAIL rstmid_async_msb got=%b exp=00001", obs_m); end
        n_checks++;
        if (obs_l !== 5'b00001) begin n_fail++; $display("FAIL rstmid_async_lsb got=%b exp=00001", obs_l); end
        q_msb.delete(); q_lsb.delete();
        @(negedge clk);
        rst = 1'b0;
        $display("reset_midframe: word %b discarded", w);
    endtask

    initial begin
        test_reset();
        test_frame(4'b1101, "single");
        test_back_to_back(4'b1101, 4'b0010);
        test_stall(4'b1101);
        test_reset_midframe(4'b0010);
        test_frame(4'b1111, "after_reset");
        test_frame(4'b1001, "parity_word");
        test_frame(4'b0110, "pattern");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
